// File: rtl/run_len_pkg.sv
// Shared types and helpers for the run-length reporter.
package run_len_pkg;

    // Run-detection state: waiting for a 1, or counting a run of 1s.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Saturation value of a w-bit run counter, 2^w - 1.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/run_len_fifo.sv
// Synchronous first-word-fall-through FIFO. The head is read straight
// from storage, so a push into an empty FIFO is visible after one edge.
module run_len_fifo
    import run_len_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_ok;
    logic             push_ok;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    // A zero head while empty keeps the outputs at their reset value.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Popping while full frees a slot for a push at the same edge.
    assign pop_ok  = pop_i && valid_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next pointer and occupancy; pointers wrap naturally as DEPTH is 2^n.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end

    // Pointer and level registers; clear wins over push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the level counter alone decides which entries are meaningful.
        if (push_ok && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/run_length_reporter.sv
// Measures runs of det_in=1, queues completed run lengths in a FWFT FIFO
// and presents the head to a valid/ready consumer.
module run_length_reporter
    import run_len_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEPTH   = 4,
    parameter int MIN_LEN = 1,
    parameter int DROP_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   det_in,
    output logic                   run_valid,
    output logic [CNT_W-1:0]       run_len,
    output logic                   run_sat,
    input  logic                   run_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_LEN);

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] len;
    } entry_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              run_end;
    logic              long_enough;
    logic              pop;
    logic              push;
    logic              full;
    entry_t            push_entry;
    entry_t            head;

    assign pop         = run_valid && run_ready;
    assign long_enough = (cnt_q >= MIN_C);
    assign push        = run_end && long_enough && (!full || pop);
    assign push_entry  = '{sat: (cnt_q == CNT_MAX), len: cnt_q};

    assign run_len  = head.len;
    assign run_sat  = head.sat;
    assign drop_cnt = drop_q;

    // Run FSM, saturating run counter and saturating drop counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        run_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (det_in) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(1);
                end
            end
            RUN: begin
                if (det_in) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    run_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A long-enough run that finds no room is lost and counted.
        if (run_end && long_enough && !push && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end

    // State registers; clr discards any run in progress and the drop count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    run_len_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_entry),
        .data_o  (head),
        .valid_o (run_valid),
        .full_o  (full),
        .level_o (fifo_level)
    );

endmodule

// File: tb/tb_run_length_reporter.sv
// Directed bench: instance A uses default parameters, instance B uses
// CNT_W=4, MIN_LEN=2, DROP_W=2 for saturation and minimum-length cases.
module tb_run_length_reporter;

    logic clk = 1'b0;
    logic reset_n;
    logic clr;

    logic       det_a, ready_a;
    logic       valid_a, sat_a;
    logic [7:0] len_a;
    logic [2:0] level_a;
    logic [7:0] drop_a;

    logic       det_b, ready_b;
    logic       valid_b, sat_b;
    logic [3:0] len_b;
    logic [2:0] level_b;
    logic [1:0] drop_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    run_length_reporter u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .det_in     (det_a),
        .run_valid  (valid_a),
        .run_len    (len_a),
        .run_sat    (sat_a),
        .run_ready  (ready_a),
        .fifo_level (level_a),
        .drop_cnt   (drop_a)
    );

    run_length_reporter #(
        .CNT_W   (4),
        .DEPTH   (4),
        .MIN_LEN (2),
        .DROP_W  (2)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .det_in     (det_b),
        .run_valid  (valid_b),
        .run_len    (len_b),
        .run_sat    (sat_b),
        .run_ready  (ready_b),
        .fifo_level (level_b),
        .drop_cnt   (drop_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One clock edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic d);
        det_a = d;
        tick();
    endtask

    task automatic step_b(input logic d);
        det_b = d;
        tick();
    endtask

    // A run of n ones followed by one terminating zero.
    task automatic run_a(input int n);
        for (int i = 0; i < n; i++) step_a(1'b1);
        step_a(1'b0);
    endtask

    task automatic run_b(input int n);
        for (int i = 0; i < n; i++) step_b(1'b1);
        step_b(1'b0);
    endtask

    task automatic pop_b();
        ready_b = 1'b1;
        step_b(1'b0);
        ready_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        clr     = 1'b0;
        det_a   = 1'b1;
        ready_a = 1'b0;
        det_b   = 1'b0;
        ready_b = 1'b0;

        // 1: reset held with det_in=1, then a run of 3.
        tick();
        tick();
        check("rst_valid", valid_a, 0);
        check("rst_len", len_a, 0);
        check("rst_level", level_a, 0);
        check("rst_drop", drop_a, 0);
        reset_n = 1'b1;
        det_a   = 1'b0;
        tick();
        step_a(1'b1);
        step_a(1'b1);
        step_a(1'b1);
        check("t1_inprogress_valid", valid_a, 0);
        step_a(1'b0);
        check("t1_valid", valid_a, 1);
        check("t1_len", len_a, 3);
        check("t1_sat", sat_a, 0);
        check("t1_level", level_a, 1);
        ready_a = 1'b1;
        step_a(1'b0);
        ready_a = 1'b0;
        check("t1_pop_valid", valid_a, 0);
        check("t1_pop_level", level_a, 0);

        // 4: five runs 1..5 with no consumer; the fifth is dropped.
        for (int l = 1; l <= 5; l++) run_a(l);
        check("t4_level", level_a, 4);
        check("t4_drop", drop_a, 1);
        step_a(1'b0);
        check("t4_hold_len", len_a, 1);
        ready_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t4_pop%0d_len", i), len_a, i);
            step_a(1'b0);
        end
        ready_a = 1'b0;
        check("t4_empty_valid", valid_a, 0);

        // 5: full FIFO, pop at the same edge a run of 7 ends.
        for (int l = 1; l <= 4; l++) run_a(l);
        check("t5_full_level", level_a, 4);
        for (int i = 0; i < 7; i++) step_a(1'b1);
        ready_a = 1'b1;
        step_a(1'b0);
        ready_a = 1'b0;
        check("t5_level", level_a, 4);
        check("t5_drop", drop_a, 1);
        ready_a = 1'b1;
        check("t5_pop0_len", len_a, 2);
        step_a(1'b0);
        check("t5_pop1_len", len_a, 3);
        step_a(1'b0);
        check("t5_pop2_len", len_a, 4);
        step_a(1'b0);
        check("t5_pop3_len", len_a, 7);
        step_a(1'b0);
        ready_a = 1'b0;
        check("t5_empty_valid", valid_a, 0);

        // 6a: asynchronous reset mid-run with two entries queued.
        run_a(1);
        run_a(2);
        for (int i = 0; i < 5; i++) step_a(1'b1);
        check("t6_pre_level", level_a, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", valid_a, 0);
        check("t6_async_len", len_a, 0);
        check("t6_async_level", level_a, 0);
        check("t6_async_drop", drop_a, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step_a(1'b0);
        check("t6_no_report_valid", valid_a, 0);
        check("t6_no_report_drop", drop_a, 0);

        // 6b: clr at the edge where a run ends into a full FIFO.
        for (int l = 1; l <= 5; l++) run_a(l);
        check("t6_clr_pre_drop", drop_a, 1);
        for (int i = 0; i < 3; i++) step_a(1'b1);
        clr = 1'b1;
        step_a(1'b0);
        clr = 1'b0;
        check("t6_clr_valid", valid_a, 0);
        check("t6_clr_len", len_a, 0);
        check("t6_clr_level", level_a, 0);
        check("t6_clr_drop", drop_a, 0);
        run_a(1);
        check("t6_after_clr_len", len_a, 1);
        check("t6_after_clr_level", level_a, 1);

        // 2: MIN_LEN=2 discards a single-cycle run silently.
        run_b(1);
        check("t2_short_valid", valid_b, 0);
        check("t2_short_drop", drop_b, 0);
        run_b(2);
        check("t2_len", len_b, 2);
        check("t2_valid", valid_b, 1);
        pop_b();

        // 3: CNT_W=4 saturation at 15.
        run_b(20);
        check("t3_len20", len_b, 15);
        check("t3_sat20", sat_b, 1);
        pop_b();
        run_b(15);
        check("t3_len15", len_b, 15);
        check("t3_sat15", sat_b, 1);
        pop_b();
        run_b(14);
        check("t3_len14", len_b, 14);
        check("t3_sat14", sat_b, 0);
        pop_b();
        check("t3_empty_valid", valid_b, 0);

        // Drop counter saturation with DROP_W=2.
        for (int i = 0; i < 4; i++) run_b(2);
        check("drop_fill_level", level_b, 4);
        for (int i = 0; i < 4; i++) run_b(2);
        check("drop_sat", drop_b, 3);
        check("drop_sat_level", level_b, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
